// File: rtl/rat_io_periph.sv
`default_nettype none
// ============================================================================
// Module   : rat_io_periph
// Brief    : Port-mapped I/O responder for the RAT MCU bus: LED register,
//            synchronized switches, 16-bit interval timer, interrupt flag.
// Revision : 1.0 - initial release
// ============================================================================
module rat_io_periph #(
    parameter logic [7:0] PORT_SW       = 8'h20,
    parameter logic [7:0] PORT_LED      = 8'h40,
    parameter logic [7:0] PORT_TMR_LO   = 8'h41,
    parameter logic [7:0] PORT_TMR_HI   = 8'h42,
    parameter logic [7:0] PORT_TMR_CTRL = 8'h43,
    parameter logic [7:0] PORT_STATUS   = 8'h44
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] PORT_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       IO_STRB,
    output logic [7:0] IN_PORT,
    output logic       INTR,
    input  logic [7:0] SWITCHES,
    output logic [7:0] LEDS
);

    logic [7:0]  r_leds_q,     w_leds_d;
    logic        r_en_q,       w_en_d;
    logic        r_auto_q,     w_auto_d;
    logic        r_irq_en_q,   w_irq_en_d;
    logic [15:0] r_reload_q,   w_reload_d;
    logic [15:0] r_count_q,    w_count_d;
    logic [15:0] r_snapshot_q, w_snapshot_d;
    logic        r_pending_q,  w_pending_d;
    logic [7:0]  r_sync1_q,    w_sync1_d;
    logic [7:0]  r_sync2_q,    w_sync2_d;

    logic w_ctrl_wr;
    logic w_start;
    logic w_expire;
    logic w_unused_ok;

    // CTRL bits [5:4] carry no function
    assign w_unused_ok = &{1'b0, OUT_PORT[5:4]};

    assign w_ctrl_wr = IO_STRB && (PORT_ID == PORT_TMR_CTRL);
    assign w_start   = w_ctrl_wr && OUT_PORT[0] && (!r_en_q || OUT_PORT[3]);
    assign w_expire  = r_en_q && !w_start && (r_count_q == 16'd0);

    always_comb begin
        w_leds_d     = r_leds_q;
        w_en_d       = r_en_q;
        w_auto_d     = r_auto_q;
        w_irq_en_d   = r_irq_en_q;
        w_reload_d   = r_reload_q;
        w_count_d    = r_count_q;
        w_snapshot_d = r_snapshot_q;
        w_pending_d  = r_pending_q;
        w_sync1_d    = SWITCHES;
        w_sync2_d    = r_sync1_q;

        if (IO_STRB) begin
            case (PORT_ID)
                PORT_LED:    w_leds_d          = OUT_PORT;
                PORT_TMR_LO: w_reload_d[7:0]   = OUT_PORT;
                PORT_TMR_HI: w_reload_d[15:8]  = OUT_PORT;
                default:     ;
            endcase
        end

        // A start load takes precedence over decrement and expiry
        if (w_start) begin
            w_count_d = r_reload_q;
        end else if (r_en_q) begin
            if (r_count_q != 16'd0) begin
                w_count_d = r_count_q - 16'd1;
            end else if (r_auto_q) begin
                w_count_d = r_reload_q;
            end else begin
                w_en_d = 1'b0;
            end
        end

        if (w_ctrl_wr) begin
            w_en_d     = OUT_PORT[0];
            w_auto_d   = OUT_PORT[1];
            w_irq_en_d = OUT_PORT[2];
            if (OUT_PORT[6]) begin
                w_snapshot_d = r_count_q;
            end
            if (OUT_PORT[7]) begin
                w_pending_d = 1'b0;
            end
        end

        // Expiry in the same cycle as an acknowledge keeps the flag set
        if (w_expire) begin
            w_pending_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_leds_q     <= 8'h00;
            r_en_q       <= 1'b0;
            r_auto_q     <= 1'b0;
            r_irq_en_q   <= 1'b0;
            r_reload_q   <= 16'h0000;
            r_count_q    <= 16'h0000;
            r_snapshot_q <= 16'h0000;
            r_pending_q  <= 1'b0;
            r_sync1_q    <= 8'h00;
            r_sync2_q    <= 8'h00;
        end else begin
            r_leds_q     <= w_leds_d;
            r_en_q       <= w_en_d;
            r_auto_q     <= w_auto_d;
            r_irq_en_q   <= w_irq_en_d;
            r_reload_q   <= w_reload_d;
            r_count_q    <= w_count_d;
            r_snapshot_q <= w_snapshot_d;
            r_pending_q  <= w_pending_d;
            r_sync1_q    <= w_sync1_d;
            r_sync2_q    <= w_sync2_d;
        end
    end

    always_comb begin
        IN_PORT = 8'h00;
        case (PORT_ID)
            PORT_SW:       IN_PORT = r_sync2_q;
            PORT_LED:      IN_PORT = r_leds_q;
            PORT_TMR_LO:   IN_PORT = r_snapshot_q[7:0];
            PORT_TMR_HI:   IN_PORT = r_snapshot_q[15:8];
            PORT_TMR_CTRL: IN_PORT = {5'b00000, r_irq_en_q, r_auto_q, r_en_q};
            PORT_STATUS:   IN_PORT = {6'b000000, r_en_q, r_pending_q};
            default:       IN_PORT = 8'h00;
        endcase
    end

    assign INTR = r_pending_q & r_irq_en_q;
    assign LEDS = r_leds_q;

endmodule
`default_nettype wire

// File: tb/tb_rat_io_periph.sv
`default_nettype none
// ============================================================================
// Module   : tb_rat_io_periph
// Brief    : Directed self-checking bench for rat_io_periph.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rat_io_periph;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] PORT_ID = 8'h00;
    logic [7:0] OUT_PORT = 8'h00;
    logic       IO_STRB = 1'b0;
    logic [7:0] IN_PORT;
    logic       INTR;
    logic [7:0] SWITCHES = 8'h00;
    logic [7:0] LEDS;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    rat_io_periph dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .PORT_ID  (PORT_ID),
        .OUT_PORT (OUT_PORT),
        .IO_STRB  (IO_STRB),
        .IN_PORT  (IN_PORT),
        .INTR     (INTR),
        .SWITCHES (SWITCHES),
        .LEDS     (LEDS)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic [7:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] d);
        PORT_ID  = id;
        OUT_PORT = d;
        IO_STRB  = 1'b1;
        tick();
        IO_STRB  = 1'b0;
    endtask

    task automatic rd_chk(input logic [7:0] id);
        PORT_ID = id;
        #1;
        check(IN_PORT);
    endtask

    task automatic intr_chk();
        check({7'b0, INTR});
    endtask

    initial begin
        // Power-on reset state
        tick();
        tick();
        push("rst_leds", 8'h00);   check(LEDS);
        push("rst_intr", 8'h00);   intr_chk();
        push("rst_status", 8'h00); rd_chk(8'h44);
        push("rst_ctrl", 8'h00);   rd_chk(8'h43);
        @(negedge CLK);
        RESET = 1'b0;
        tick();

        // LED register and unmapped readback
        wr(8'h40, 8'hA5);
        push("led_out", 8'hA5);    check(LEDS);
        push("led_rd", 8'hA5);     rd_chk(8'h40);
        push("unmapped_rd", 8'h00); rd_chk(8'h7F);

        // Reset mid-count with reload 0x0123
        wr(8'h41, 8'h23);
        wr(8'h42, 8'h01);
        wr(8'h43, 8'h05);
        tick();
        wr(8'h43, 8'h45);
        push("run_status", 8'h02); rd_chk(8'h44);
        push("run_snap_hi", 8'h01); rd_chk(8'h42);
        #1;
        RESET = 1'b1;
        #1;
        push("arst_leds", 8'h00);   check(LEDS);
        push("arst_intr", 8'h00);   intr_chk();
        push("arst_status", 8'h00); rd_chk(8'h44);
        push("arst_lo", 8'h00);     rd_chk(8'h41);
        push("arst_hi", 8'h00);     rd_chk(8'h42);
        @(negedge CLK);
        RESET = 1'b0;
        tick();
        tick();
        tick();
        push("arst_stopped", 8'h00); rd_chk(8'h44);

        // One-shot: reload 3, expiry visible after T+4
        wr(8'h41, 8'h03);
        wr(8'h42, 8'h00);
        wr(8'h43, 8'h05);           // edge T
        tick();
        tick();
        tick();                     // after T+3
        push("os_intr_t3", 8'h00);  intr_chk();
        push("os_status_t3", 8'h02); rd_chk(8'h44);
        tick();                     // after T+4
        push("os_intr_t4", 8'h01);  intr_chk();
        push("os_status_t4", 8'h01); rd_chk(8'h44);
        wr(8'h43, 8'h84);
        push("os_ack_intr", 8'h00); intr_chk();
        push("os_ack_ctrl", 8'h04); rd_chk(8'h43);
        push("os_ack_status", 8'h00); rd_chk(8'h44);

        // Auto-reload with snapshot, reload 2
        wr(8'h41, 8'h02);
        wr(8'h42, 8'h00);
        wr(8'h43, 8'h07);           // edge T, count 2
        tick();                     // T+1, count 1
        wr(8'h43, 8'h47);           // T+2, snapshot captures 1
        push("snap_lo", 8'h01);     rd_chk(8'h41);
        push("snap_hi", 8'h00);     rd_chk(8'h42);
        tick();                     // T+3 expiry
        push("auto_intr_t3", 8'h01); intr_chk();
        wr(8'h43, 8'h87);           // T+4 ack
        push("auto_ack_t4", 8'h00); intr_chk();
        tick();                     // T+5
        push("auto_intr_t5", 8'h00); intr_chk();
        wr(8'h43, 8'h87);           // T+6 ack collides with expiry
        push("coll_intr", 8'h01);   intr_chk();
        push("coll_status", 8'h03); rd_chk(8'h44);
        wr(8'h43, 8'h87);           // T+7 ack
        push("post_coll_intr", 8'h00); intr_chk();
        push("post_coll_status", 8'h02); rd_chk(8'h44);
        tick();                     // T+8
        push("auto_intr_t8", 8'h00); intr_chk();
        tick();                     // T+9 expiry
        push("auto_intr_t9", 8'h01); intr_chk();

        // Masking: IRQ_EN cleared, pending kept
        wr(8'h43, 8'h03);
        push("mask_intr", 8'h00);   intr_chk();
        push("mask_status", 8'h03); rd_chk(8'h44);
        push("mask_ctrl", 8'h03);   rd_chk(8'h43);

        // Switch synchronizer
        SWITCHES = 8'h3C;
        tick();
        push("sw_1edge", 8'h00);    rd_chk(8'h20);
        tick();
        push("sw_2edge", 8'h3C);    rd_chk(8'h20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
